// File: rtl/ram_ctrl_pkg.sv
// Shared opcodes, command-control width and FSM state encoding for the RAM access arbiter.
package ram_ctrl_pkg;

    localparam int CTRL_WIDTH = 2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RCMD  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: the requester that did not win last time has priority.
module rr_arbiter_2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_any_req
);

    always_comb begin
        o_any_req = |i_req;
        o_grant   = 2'b00;
        if (i_last_grant) begin
            if (i_req[0])      o_grant = 2'b01;
            else if (i_req[1]) o_grant = 2'b10;
        end else begin
            if (i_req[1])      o_grant = 2'b10;
            else if (i_req[0]) o_grant = 2'b01;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a command-driven single-port RAM between two requesters, turning each
// transaction into an address command plus a data/read command and returning a response pulse.
module ram_access_arbiter #(
    parameter int ADDR_SIZE      = 8,
    parameter int WORD_SIZE      = 8,
    parameter int CTRL_WIDTH     = 2,
    parameter int DIN_WIDTH      = WORD_SIZE + CTRL_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_req_valid,
    input  logic [1:0]             i_req_we,
    input  logic [2*ADDR_SIZE-1:0] i_req_addr,
    input  logic [2*WORD_SIZE-1:0] i_req_wdata,
    output logic [1:0]             o_req_ready,
    output logic [1:0]             o_rsp_valid,
    output logic [WORD_SIZE-1:0]   o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_ram_rx_valid,
    output logic [DIN_WIDTH-1:0]   o_ram_din,
    input  logic                   i_ram_tx_valid,
    input  logic [WORD_SIZE-1:0]   i_ram_dout
);

    import ram_ctrl_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 r_state;
    logic                   r_gnt;
    logic                   r_last_grant;
    logic                   r_we;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ram_rx_valid;
    logic [DIN_WIDTH-1:0]   r_ram_din;
    logic [1:0]             r_rsp_valid;
    logic [WORD_SIZE-1:0]   r_rsp_rdata;
    logic                   r_rsp_err;

    logic [1:0]             w_grant;
    logic                   w_any_req;
    logic                   w_gidx;
    logic [ADDR_SIZE-1:0]   w_addr;

    function automatic logic [DIN_WIDTH-1:0] cmd(input logic [1:0] op, input logic [WORD_SIZE-1:0] pl);
        return {CTRL_WIDTH'(op), pl};
    endfunction

    rr_arbiter_2 u_arb (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    assign w_gidx = w_grant[1];
    assign w_addr = i_req_addr[w_gidx*ADDR_SIZE +: ADDR_SIZE];

    // Gated by reset so no accept is advertised in a cycle that cannot latch it.
    assign o_req_ready    = (r_state == ST_IDLE && !i_rst) ? w_grant : 2'b00;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_ram_rx_valid = r_ram_rx_valid;
    assign o_ram_din      = r_ram_din;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_err      = r_rsp_err;

    // Outputs are registered on entry to the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_gnt          <= 1'b0;
            r_last_grant   <= 1'b1;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_cnt          <= '0;
            r_ram_rx_valid <= 1'b0;
            r_ram_din      <= '0;
            r_rsp_valid    <= 2'b00;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_ram_rx_valid <= 1'b0;
            r_ram_din      <= '0;
            r_rsp_valid    <= 2'b00;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt          <= w_gidx;
                        r_last_grant   <= w_gidx;
                        r_we           <= i_req_we[w_gidx];
                        r_wdata        <= i_req_wdata[w_gidx*WORD_SIZE +: WORD_SIZE];
                        r_ram_rx_valid <= 1'b1;
                        r_ram_din      <= cmd(i_req_we[w_gidx] ? OP_WR_ADDR : OP_RD_ADDR,
                                              WORD_SIZE'(w_addr));
                        r_state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_ram_rx_valid <= 1'b1;
                    r_ram_din      <= r_we ? cmd(OP_WR_DATA, r_wdata) : cmd(OP_RD_DATA, '0);
                    r_state        <= r_we ? ST_WDATA : ST_RCMD;
                end
                ST_WDATA: begin
                    r_rsp_valid[r_gnt] <= 1'b1;
                    r_state            <= ST_RESP;
                end
                ST_RCMD: begin
                    r_cnt   <= '0;
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (i_ram_tx_valid) begin
                        r_rsp_valid[r_gnt] <= 1'b1;
                        r_rsp_rdata        <= i_ram_dout;
                        r_state            <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_valid[r_gnt] <= 1'b1;
                        r_rsp_err          <= 1'b1;
                        r_state            <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench: accepts push expected commands/responses, a negedge monitor pops and compares.
module tb_ram_access_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv [2];
    logic        rwe[2];
    logic [7:0]  raddr[2];
    logic [7:0]  rwd[2];
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  rsp_rdata, ram_dout;
    logic        rsp_err, busy, ram_rx_valid, ram_tx_valid;
    logic [9:0]  ram_din;

    always #5 clk = ~clk;

    assign req_valid = {rv[1], rv[0]};
    assign req_we    = {rwe[1], rwe[0]};
    assign req_addr  = {raddr[1], raddr[0]};
    assign req_wdata = {rwd[1], rwd[0]};

    ram_access_arbiter #(.ADDR_SIZE(8), .WORD_SIZE(8), .CTRL_WIDTH(2), .DIN_WIDTH(10),
                         .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_busy(busy), .o_ram_rx_valid(ram_rx_valid), .o_ram_din(ram_din),
        .i_ram_tx_valid(ram_tx_valid), .i_ram_dout(ram_dout)
    );

    // Command-driven RAM: address ops load the address register and drop tx_valid.
    logic [7:0] ram_mem[256];
    logic [7:0] ram_ar = 8'h00;
    bit         ram_mute = 1'b0;
    initial begin
        ram_tx_valid = 1'b0;
        ram_dout     = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00, 2'b10: begin ram_ar <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
                2'b01: ram_mem[ram_ar] <= ram_din[7:0];
                default: if (!ram_mute) begin ram_dout <= ram_mem[ram_ar]; ram_tx_valid <= 1'b1; end
            endcase
        end
    end

    // Reference model state
    typedef struct { int g; bit we; logic [7:0] addr; logic [7:0] wdata;
                     logic [7:0] rdata; bit err; int cyc; } rsp_t;
    typedef struct { logic [9:0] din; int cyc; } cmd_t;
    rsp_t       exp_q[$];
    cmd_t       cmd_q[$];
    int         gq[$];
    logic [7:0] rmem[256];
    int         last_g = 1;
    int         cyc = 0;
    int         nchk = 0, nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cmd_q.delete();
            last_g = 1;
        end else begin
            logic [1:0] eg;
            chk("busy", busy, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("ready_while_busy", req_ready, 2'b00);
            end else begin
                // Contention goes to whoever did not win last; otherwise the lone requester.
                eg = (req_valid == 2'b11) ? ((last_g == 1) ? 2'b01 : 2'b10) : req_valid;
                chk("grant", req_ready, eg);
                if (eg != 2'b00) begin
                    rsp_t r;
                    int   g;
                    g = (eg == 2'b10) ? 1 : 0;
                    last_g = g;
                    gq.push_back(g);
                    r.g = g; r.we = req_we[g]; r.addr = raddr[g]; r.wdata = rwd[g];
                    if (r.we) begin
                        r.rdata = 8'h00; r.err = 1'b0; r.cyc = cyc + 3;
                        cmd_q.push_back('{din: {2'b00, r.addr}, cyc: cyc + 1});
                        cmd_q.push_back('{din: {2'b01, r.wdata}, cyc: cyc + 2});
                    end else begin
                        if (ram_mute) begin r.rdata = 8'h00; r.err = 1'b1; r.cyc = cyc + 3 + TO; end
                        else          begin r.rdata = rmem[r.addr]; r.err = 1'b0; r.cyc = cyc + 4; end
                        cmd_q.push_back('{din: {2'b10, r.addr}, cyc: cyc + 1});
                        cmd_q.push_back('{din: {2'b11, 8'h00}, cyc: cyc + 2});
                    end
                    exp_q.push_back(r);
                end
            end
            if (ram_rx_valid) begin
                if (cmd_q.size() == 0) chk("unexpected_cmd", ram_din, 10'h3ff);
                else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    chk("cmd_din", ram_din, c.din);
                    chk("cmd_cycle", cyc, c.cyc);
                end
            end else if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
                chk("cmd_missing", 0, 1);
                void'(cmd_q.pop_front());
            end
            if (rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 2'b00);
                else begin
                    rsp_t r;
                    r = exp_q.pop_front();
                    chk("rsp_valid", rsp_valid, 2'b01 << r.g);
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", rsp_err, r.err);
                    chk("rsp_cycle", cyc, r.cyc);
                    if (r.we) rmem[r.addr] = r.wdata;
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                chk("rsp_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
        bit got = 1'b0;
        rv[i] = 1'b1; rwe[i] = we; raddr[i] = a; rwd[i] = d;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        if (!got) chk("accept_timeout", {31'd0, got}, 1);
        @(posedge clk); #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) chk("idle_timeout", {31'd0, done}, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin ram_mem[k] = 8'h00; rmem[k] = 8'h00; end
        for (int k = 0; k < 2; k++) begin rv[k] = 1'b0; rwe[k] = 1'b0; raddr[k] = 8'h00; rwd[k] = 8'h00; end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", ram_rx_valid, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", {rsp_err, rsp_rdata}, 0);
        @(posedge clk); #1; rst = 1'b0;

        issue(0, 1'b1, 8'h3C, 8'hA5);
        wait_idle();
        issue(1, 1'b0, 8'h3C, 8'h00);
        wait_idle();

        gq.delete();
        fork
            begin issue(0, 1'b1, 8'h10, 8'h01); issue(0, 1'b0, 8'h10, 8'h00); end
            begin issue(1, 1'b1, 8'h20, 8'h02); issue(1, 1'b0, 8'h20, 8'h00); end
        join
        wait_idle();
        chk("order_len", gq.size(), 4);
        if (gq.size() == 4) chk("order", {gq[0], gq[1], gq[2], gq[3]}, {32'd0, 32'd1, 32'd0, 32'd1});

        ram_mute = 1'b1;
        issue(0, 1'b0, 8'h3C, 8'h00);
        wait_idle();
        ram_mute = 1'b0;

        // Reset lands on the edge that would enter the data phase of a write.
        issue(1, 1'b1, 8'h00, 8'hEE);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rx_valid", ram_rx_valid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        issue(0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        issue(1, 1'b1, 8'h00, 8'h5A);
        wait_idle();
        issue(0, 1'b0, 8'h00, 8'h00);
        wait_idle();

        issue(0, 1'b1, 8'hFF, 8'h11);
        wait_idle();
        issue(1, 1'b1, 8'h00, 8'h22);
        wait_idle();
        issue(0, 1'b0, 8'hFF, 8'h00);
        issue(1, 1'b0, 8'h00, 8'h00);
        wait_idle();

        fork
            begin
                for (int n = 0; n < 15; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 issue(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)) | 8'($urandom_range(0, 1) * 8'hF8),
                             8'($urandom));
                end
            end
            begin
                for (int n = 0; n < 15; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 issue(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)) | 8'($urandom_range(0, 1) * 8'hF8),
                             8'($urandom));
                end
            end
        join
        wait_idle();
        chk("drain_rsp", exp_q.size(), 0);
        chk("drain_cmd", cmd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
